// File: rtl/score_display_if.sv
// Bundles the score-display data path: binary score and game controls in, segment drives and status out.
`timescale 1ns/1ps
interface score_display_if;
  logic [6:0] score;
  logic       game_over;
  logic       clear_high;
  logic [7:0] ss0;
  logic [7:0] ss1;
  logic [7:0] ss2;
  logic [7:0] ss3;
  logic       busy;
  logic       new_high;

  modport master (
    output score, game_over, clear_high,
    input  ss0, ss1, ss2, ss3, busy, new_high
  );

  modport slave (
    input  score, game_over, clear_high,
    output ss0, ss1, ss2, ss3, busy, new_high
  );
endinterface

// File: rtl/score_display.sv
// Score to 7-segment display with session high score; sequential double-dabble, 8 cycles from sample to display.
// No backpressure: score changes while busy are skipped and the latest value is converted on return to idle.
`timescale 1ns/1ps
module score_display #(
  parameter int BLINK_DIV = 50,
  parameter int MAX_SCORE = 99
) (
  input  logic clk,
  input  logic nRst_i,
  score_display_if.slave bus
);
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [6:0] MAX_S = 7'(MAX_SCORE);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [6:0]      sat, last_score, high_bin;
  logic [14:0]     sr;
  logic [2:0]      cnt;
  logic [3:0]      cur_tens, cur_units, high_tens, high_units;
  logic            busy_q, new_high_q, gov_q, pending, phase;
  logic [CW-1:0]   blink_cnt;
  logic            load, do_shift, finish, commit, go_rise, blank;

  function automatic logic [14:0] dabble(input logic [14:0] s);
    logic [3:0] t, u;
    t = (s[14:11] >= 4'd5) ? s[14:11] + 4'd3 : s[14:11];
    u = (s[10:7]  >= 4'd5) ? s[10:7]  + 4'd3 : s[10:7];
    return {t, u, s[6:0]} << 1;
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 8'h3F;
      4'd1: seg7 = 8'h06;
      4'd2: seg7 = 8'h5B;
      4'd3: seg7 = 8'h4F;
      4'd4: seg7 = 8'h66;
      4'd5: seg7 = 8'h6D;
      4'd6: seg7 = 8'h7D;
      4'd7: seg7 = 8'h07;
      4'd8: seg7 = 8'h7F;
      4'd9: seg7 = 8'h6F;
      default: seg7 = 8'h00;
    endcase
  endfunction

  assign sat     = (bus.score > MAX_S) ? MAX_S : bus.score;
  assign go_rise = bus.game_over & ~gov_q;
  // Commit only once the display reflects the score that ended the game.
  assign commit  = (state_q == IDLE) && (sat == last_score) && pending;

  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    do_shift = 1'b0;
    finish   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sat != last_score) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        do_shift = 1'b1;
        if (cnt == 3'd6) state_d = DONE;
      end
      DONE: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) begin
      sr         <= '0;
      cnt        <= '0;
      last_score <= '0;
      busy_q     <= 1'b0;
      cur_tens   <= '0;
      cur_units  <= '0;
    end else begin
      if (load) begin
        sr         <= {8'h00, sat};
        last_score <= sat;
        cnt        <= '0;
        busy_q     <= 1'b1;
      end
      if (do_shift) begin
        sr  <= dabble(sr);
        cnt <= cnt + 3'd1;
      end
      if (finish) begin
        cur_tens  <= sr[14:11];
        cur_units <= sr[10:7];
        busy_q    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) begin
      gov_q      <= 1'b0;
      pending    <= 1'b0;
      high_bin   <= '0;
      high_tens  <= '0;
      high_units <= '0;
      new_high_q <= 1'b0;
    end else begin
      gov_q <= bus.game_over;
      if (bus.clear_high) begin
        high_bin   <= '0;
        high_tens  <= '0;
        high_units <= '0;
        new_high_q <= 1'b0;
        pending    <= 1'b0;
      end else begin
        if (commit) begin
          pending <= 1'b0;
          if (last_score > high_bin) begin
            high_bin   <= last_score;
            high_tens  <= cur_tens;
            high_units <= cur_units;
            new_high_q <= 1'b1;
          end
        end
        if (go_rise) pending <= 1'b1;
        if (load && sat == 7'd0) new_high_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign blank        = new_high_q & ~phase;
  assign bus.ss0      = blank ? 8'h00 : seg7(cur_units);
  assign bus.ss1      = (blank || cur_tens == 4'd0) ? 8'h00 : seg7(cur_tens);
  assign bus.ss2      = seg7(high_units);
  assign bus.ss3      = (high_tens == 4'd0) ? 8'h00 : seg7(high_tens);
  assign bus.busy     = busy_q;
  assign bus.new_high = new_high_q;
endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: expected displays queued by stimulus, popped by a monitor on each conversion end.
`timescale 1ns/1ps
module tb_score_display;
  localparam int BLINK_DIV = 50;

  logic clk = 1'b0;
  logic nRst_i;
  int   checks = 0;
  int   passes = 0;
  int   unexpected = 0;
  logic [15:0] exp_q[$];

  score_display_if ifc();

  score_display #(.BLINK_DIV(BLINK_DIV), .MAX_SCORE(99)) dut (
    .clk    (clk),
    .nRst_i (nRst_i),
    .bus    (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    tick(1);
    while (ifc.busy && n < 20) begin
      tick(1);
      n++;
    end
    if (ifc.busy) chk("idle_timeout", ifc.busy, 0);
    tick(1);
  endtask

  // Expected entries are {ss1, ss0}; a blanked units digit delays the compare.
  initial begin : monitor
    logic        busy_prev;
    logic [15:0] e;
    int          n;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!nRst_i) begin
        busy_prev = 1'b0;
      end else begin
        if (busy_prev && !ifc.busy) begin
          if (exp_q.size() == 0) begin
            unexpected++;
          end else begin
            e = exp_q.pop_front();
            n = 0;
            while (ifc.ss0 == 8'h00 && n < BLINK_DIV + 2) begin
              @(negedge clk);
              n++;
            end
            chk("disp_ss0", ifc.ss0, e[7:0]);
            chk("disp_ss1", ifc.ss1, e[15:8]);
          end
        end
        busy_prev = ifc.busy;
      end
    end
  end

  initial begin : stim
    int busy_seen, blanks, hi_blank;
    nRst_i = 1'b0;
    ifc.score = 7'd0;
    ifc.game_over = 1'b0;
    ifc.clear_high = 1'b0;
    tick(3);
    chk("rst_ss0", ifc.ss0, 8'h3F);
    chk("rst_ss1", ifc.ss1, 8'h00);
    chk("rst_ss2", ifc.ss2, 8'h3F);
    chk("rst_ss3", ifc.ss3, 8'h00);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_new_high", ifc.new_high, 0);
    nRst_i = 1'b1;

    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (ifc.busy) busy_seen++;
    end
    chk("idle_zero_busy", busy_seen, 0);
    chk("idle_zero_ss0", ifc.ss0, 8'h3F);

    // 47: busy from edge N through N+7, display updates at N+8
    ifc.score = 7'd47;
    exp_q.push_back({8'h66, 8'h07});
    @(posedge clk); #1;
    chk("lat_busy_n0", ifc.busy, 1);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("lat_busy_n%0d", k), ifc.busy, (k < 8) ? 1 : 0);
      chk($sformatf("lat_ss0_n%0d", k), ifc.ss0, (k < 8) ? 8'h3F : 8'h07);
      chk($sformatf("lat_ss1_n%0d", k), ifc.ss1, (k < 8) ? 8'h00 : 8'h66);
    end

    tick(1);
    ifc.score = 7'd115;
    exp_q.push_back({8'h6F, 8'h6F});
    wait_idle();
    ifc.score = 7'd5;
    exp_q.push_back({8'h00, 8'h6D});
    wait_idle();

    ifc.score = 7'd42;
    exp_q.push_back({8'h66, 8'h5B});
    wait_idle();
    ifc.game_over = 1'b1;
    tick(1);
    ifc.game_over = 1'b0;
    tick(3);
    chk("hi42_ss3", ifc.ss3, 8'h66);
    chk("hi42_ss2", ifc.ss2, 8'h5B);
    chk("hi42_new_high", ifc.new_high, 1);
    blanks = 0;
    hi_blank = 0;
    for (int i = 0; i < 2 * BLINK_DIV; i++) begin
      tick(1);
      if (ifc.ss0 == 8'h00 && ifc.ss1 == 8'h00) blanks++;
      if (ifc.ss3 != 8'h66 || ifc.ss2 != 8'h5B) hi_blank++;
    end
    chk("blink_blank_cycles", blanks, BLINK_DIV);
    chk("blink_high_steady", hi_blank, 0);

    ifc.score = 7'd30;
    ifc.game_over = 1'b1;
    exp_q.push_back({8'h4F, 8'h3F});
    wait_idle();
    tick(3);
    ifc.game_over = 1'b0;
    chk("lower_ss3", ifc.ss3, 8'h66);
    chk("lower_ss2", ifc.ss2, 8'h5B);
    chk("lower_new_high", ifc.new_high, 1);
    tick(2 * BLINK_DIV);

    ifc.score = 7'd0;
    exp_q.push_back({8'h00, 8'h3F});
    wait_idle();
    chk("newgame_new_high", ifc.new_high, 0);
    chk("newgame_ss3", ifc.ss3, 8'h66);

    ifc.score = 7'd10;
    exp_q.push_back({8'h06, 8'h3F});
    tick(1);
    ifc.score = 7'd11;
    tick(1);
    ifc.score = 7'd12;
    exp_q.push_back({8'h06, 8'h5B});
    tick(18);
    chk("burst_ss1", ifc.ss1, 8'h06);
    chk("burst_ss0", ifc.ss0, 8'h5B);

    ifc.score = 7'd60;
    exp_q.push_back({8'h7D, 8'h3F});
    wait_idle();
    ifc.game_over = 1'b1;
    tick(1);
    ifc.clear_high = 1'b1;
    tick(1);
    ifc.clear_high = 1'b0;
    chk("clr_ss2", ifc.ss2, 8'h3F);
    chk("clr_ss3", ifc.ss3, 8'h00);
    chk("clr_new_high", ifc.new_high, 0);
    tick(4);
    chk("clr_late_ss3", ifc.ss3, 8'h00);
    chk("clr_late_new_high", ifc.new_high, 0);
    ifc.game_over = 1'b0;
    tick(2);

    ifc.score = 7'd25;
    exp_q.push_back({8'h5B, 8'h6D});
    wait_idle();
    ifc.game_over = 1'b1;
    tick(1);
    ifc.game_over = 1'b0;
    tick(3);
    chk("hi25_ss3", ifc.ss3, 8'h5B);
    chk("hi25_ss2", ifc.ss2, 8'h6D);

    ifc.score = 7'd77;
    tick(3);
    chk("busy_before_reset", ifc.busy, 1);
    #2 nRst_i = 1'b0;
    #1;
    chk("midrst_busy", ifc.busy, 0);
    chk("midrst_ss0", ifc.ss0, 8'h3F);
    chk("midrst_ss1", ifc.ss1, 8'h00);
    chk("midrst_ss2", ifc.ss2, 8'h3F);
    chk("midrst_ss3", ifc.ss3, 8'h00);
    chk("midrst_new_high", ifc.new_high, 0);
    tick(2);
    nRst_i = 1'b1;
    exp_q.push_back({8'h07, 8'h07});
    wait_idle();
    tick(2);

    chk("queue_drained", exp_q.size(), 0);
    chk("unexpected_updates", unexpected, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
